// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit: forwarding select
// codes and the shadow-pipeline entry that tracks in-flight instructions.
package hazard_pkg;

  // Operand-mux select codes; 2'b11 is never produced.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Register indices are stored zero-extended to this width so the entry type
  // can live in the package; REG_ADDR_W of the unit must not exceed it.
  localparam int unsigned MAX_REG_ADDR_W = 8;

  typedef logic [MAX_REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      reg_write;
    logic      is_load;
    reg_addr_t rs1;
    reg_addr_t rs2;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_BUBBLE = '0;

  // True when entry e will write a nonzero register equal to r.
  function automatic logic fwd_hit(input shadow_entry_t e, input reg_addr_t r);
    return e.valid & e.reg_write & (e.rd != '0) & (e.rd == r);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority comparison for one execute-stage operand: the memory-stage result is
// newer than the writeback-stage result, so it wins when both match.
import hazard_pkg::*;

module fwd_select (
  input  shadow_entry_t mem,
  input  shadow_entry_t wb,
  input  reg_addr_t     rs,
  output logic [1:0]    sel
);

  // Fields that play no part in forwarding.
  logic unused_fields;
  assign unused_fields = ^{mem.is_load, mem.rs1, mem.rs2, wb.is_load, wb.rs1, wb.rs2};

  // Pick the newest producer of rs, falling back to the register file.
  always_comb begin
    sel = FWD_RF;
    if (fwd_hit(mem, rs)) begin
      sel = FWD_MEM;
    end else if (fwd_hit(wb, rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks EX/MEM/WB in a shadow pipeline, drives operand
// forwarding selects, load-use stalls and branch flushes.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
import hazard_pkg::*;

module hazard_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  ex_branch_taken,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic                  flush_id_ex
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
`endif
);

  shadow_entry_t ex_q, ex_d;
  shadow_entry_t mem_q;
  shadow_entry_t wb_q;

  reg_addr_t id_rs1_x, id_rs2_x, id_rd_x;
  logic      load_use;

  assign id_rs1_x = reg_addr_t'(id_rs1);
  assign id_rs2_x = reg_addr_t'(id_rs2);
  assign id_rd_x  = reg_addr_t'(id_rd);

  // Load-use detection; a taken branch squashes the dependent instruction, so
  // it overrides the stall.
  always_comb begin
    load_use = ex_q.valid & ex_q.is_load & (ex_q.rd != '0) &
               ((id_use_rs1 & (id_rs1_x == ex_q.rd)) |
                (id_use_rs2 & (id_rs2_x == ex_q.rd)));
    stall_if_id = load_use & ~ex_branch_taken;
    flush_if_id = ex_branch_taken;
    flush_id_ex = ex_branch_taken | load_use;
  end

  // Next EX entry: the decode instruction, or a bubble when it must not advance.
  always_comb begin
    ex_d = SHADOW_BUBBLE;
    if (!(stall_if_id | flush_id_ex)) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = id_rd_x;
      ex_d.reg_write = id_reg_write;
      ex_d.is_load   = id_is_load;
      ex_d.rs1       = id_rs1_x;
      ex_d.rs2       = id_rs2_x;
    end
  end

  // Shadow pipeline advance; reset drains every stage to a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= SHADOW_BUBBLE;
      mem_q <= SHADOW_BUBBLE;
      wb_q  <= SHADOW_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  fwd_select u_fwd_a (
    .mem (mem_q),
    .wb  (wb_q),
    .rs  (ex_q.rs1),
    .sel (fwd_a_sel)
  );

  fwd_select u_fwd_b (
    .mem (mem_q),
    .wb  (wb_q),
    .rs  (ex_q.rs2),
    .sel (fwd_b_sel)
  );

  // EX-stage write info is only needed through the MEM/WB copies.
  logic unused_ex;
  assign unused_ex = ^{ex_q.reg_write};

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_if_id && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_if_id && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed, table-driven bench for hazard_unit.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_reg_write, id_is_load, ex_branch_taken;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall_if_id, flush_if_id, flush_id_ex;
`ifdef HAZARD_PERF_CNT_EN
  logic [3:0] stall_count, flush_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_unit #(
    .REG_ADDR_W (5),
    .CNT_W      (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_is_load      (id_is_load),
    .ex_branch_taken (ex_branch_taken),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .stall_if_id     (stall_if_id),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_count     (stall_count),
    .flush_count     (flush_count)
`endif
  );

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       br;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic       fif;
    logic       fex;
  } vec_t;

  vec_t vecs[34];

  function automatic vec_t mk(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic rw, input logic ld, input logic br,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic st, input logic fif, input logic fex);
    vec_t v;
    v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.rw = rw; v.ld = ld; v.br = br; v.fa = fa; v.fb = fb; v.st = st;
    v.fif = fif; v.fex = fex;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst_n           = v.rst;
    id_rs1          = v.rs1;
    id_rs2          = v.rs2;
    id_use_rs1      = v.u1;
    id_use_rs2      = v.u2;
    id_rd           = v.rd;
    id_reg_write    = v.rw;
    id_is_load      = v.ld;
    ex_branch_taken = v.br;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                            input logic st, input logic fif, input logic fex);
    check({tag, "_fwd_a"}, 32'(fwd_a_sel), 32'(fa));
    check({tag, "_fwd_b"}, 32'(fwd_b_sel), 32'(fb));
    check({tag, "_stall"}, 32'(stall_if_id), 32'(st));
    check({tag, "_flush_if_id"}, 32'(flush_if_id), 32'(fif));
    check({tag, "_flush_id_ex"}, 32'(flush_id_ex), 32'(fex));
  endtask

  // Drive one cycle of stimulus at the falling edge, then settle.
  task automatic step(input vec_t v);
    @(negedge clk);
    apply(v);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t nop, lw8, add9, nop_br;
    nop    = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop_br = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    lw8    = mk(1, 3, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0);
    add9   = mk(1, 8, 2, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0);

    // x5 produced, consumed back-to-back (MEM forward)
    vecs[0]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // x5 consumed two later on rs2 (WB forward)
    vecs[4]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 1, 5, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // x5 written twice then read on both operands: MEM beats WB
    vecs[8]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 5, 5, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0);
    vecs[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // lw x8; add x9,x8,x2: one stall, then WB forward
    vecs[13] = mk(1, 3, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(1, 8, 2, 1, 1, 9, 1, 0, 0, 0, 0, 1, 0, 1);
    vecs[15] = mk(1, 8, 2, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[16] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // x0 writes (ALU and load) then x0 reads: nothing happens
    vecs[17] = mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[18] = mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[19] = mk(1, 0, 0, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[20] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // load-use coincident with taken branch: branch wins; lw's rs1=x3 hits WB
    vecs[21] = mk(1, 3, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[22] = mk(1, 8, 2, 1, 1, 9, 1, 0, 1, 1, 0, 0, 1, 1);
    vecs[23] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // load-use through rs2
    vecs[24] = mk(1, 0, 0, 1, 0, 12, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[25] = mk(1, 1, 12, 1, 1, 14, 1, 0, 0, 0, 0, 1, 0, 1);
    vecs[26] = mk(1, 1, 12, 1, 1, 14, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[27] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // rs2 field matches the load but is unused: no stall
    vecs[28] = mk(1, 0, 0, 1, 0, 12, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[29] = mk(1, 1, 12, 1, 0, 13, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[30] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    vecs[31] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // plain taken branch
    vecs[32] = mk(1, 1, 2, 1, 1, 5, 1, 0, 1, 0, 0, 0, 1, 1);
    vecs[33] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset with a load-use pattern on the decode inputs, which must be ignored.
    step(mk(0, 8, 8, 1, 1, 8, 1, 1, 0, 0, 0, 0, 0, 0));
    step(mk(0, 8, 2, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0));
    step(nop);
    check_outs("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    check("reset_stall_count", 32'(stall_count), 32'd0);
    check("reset_flush_count", 32'(flush_count), 32'd0);
`endif

    for (int i = 0; i < 34; i++) begin
      step(vecs[i]);
      check_outs($sformatf("vec%0d", i), vecs[i].fa, vecs[i].fb, vecs[i].st,
                 vecs[i].fif, vecs[i].fex);
    end

    // Reset in the middle of a load-use stall cancels it.
    step(lw8);
    step(add9);
    check("midrst_pre_stall", 32'(stall_if_id), 32'd1);
    step(mk(0, 8, 2, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0));
    step(add9);
    check_outs("midrst_release", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    check("midrst_stall_count", 32'(stall_count), 32'd0);
    check("midrst_flush_count", 32'(flush_count), 32'd0);
`endif
    step(nop);
    check_outs("midrst_after", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

`ifdef HAZARD_PERF_CNT_EN
    // Flush counter: 3 counted, then saturation at 15.
    for (int i = 0; i < 3; i++) step(nop_br);
    step(nop);
    check("flush_count_3", 32'(flush_count), 32'd3);
    for (int i = 0; i < 17; i++) step(nop_br);
    step(nop);
    check("flush_count_sat", 32'(flush_count), 32'd15);
    check("stall_count_no_branch", 32'(stall_count), 32'd0);
    // Stall counter saturation through 17 load-use hazards.
    for (int i = 0; i < 17; i++) begin
      step(lw8);
      step(add9);
      step(add9);
    end
    step(nop);
    check("stall_count_sat", 32'(stall_count), 32'd15);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter: REG_ADDR_W, default 5, meaning register-index width.
REQ-002 Parameter: CNT_W, default 32, meaning perf-counter width (used only with HAZARD_PERF_CNT_EN).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 id_rs1, id_rs2  input  REG_ADDR_W each  source registers of instruction in decode.
REQ-006 id_use_rs1, id_use_rs2  input  1 each  decode instruction actually reads rs1/rs2.
REQ-007 id_rd  input  REG_ADDR_W  destination of decode instruction.
REQ-008 id_reg_write  input  1  decode instruction writes register file.
REQ-009 id_is_load  input  1  decode instruction is a load.
REQ-010 ex_branch_taken  input  1  branch/jump resolved taken in execute this cycle.
REQ-011 fwd_a_sel, fwd_b_sel  output  2 each  select codes for execute-stage operand 3-to-1 muxes.
REQ-012 stall_if_id  output  1  hold PC and IF/ID register.
REQ-013 flush_if_id, flush_id_ex  output  1 each  bubble the named pipeline register.

Function
REQ-014 Select encoding SHALL be: 2'b00 register-file value, 2'b01 writeback-stage result, 2'b10 memory-stage ALU result; 2'b11 never driven.
REQ-015 Unit SHALL keep a shadow pipeline of three entries (EX, MEM, WB), each {valid, rd, reg_write, is_load, rs1, rs2}.
REQ-016 Each cycle: WB <= MEM, MEM <= EX; EX <= decode inputs unless stall or flush, in which case EX <= bubble (valid=0).
REQ-017 fwd_a_sel SHALL be 2'b10 when MEM.valid & MEM.reg_write & MEM.rd!=0 & MEM.rd==EX.rs1; else 2'b01 when same test on WB; else 2'b00. fwd_b_sel identical using EX.rs2.
REQ-018 MEM match SHALL take priority over WB match (newest value wins).
REQ-019 Register 0 SHALL never be forwarded.
REQ-020 Forward selects SHALL be combinational from shadow state (zero-cycle latency after clock edge).
REQ-021 Load-use: stall_if_id=1 and flush_id_ex=1 when EX.valid & EX.is_load & EX.rd!=0 & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)); exactly one stall cycle per hazard.
REQ-022 ex_branch_taken=1 SHALL assert flush_if_id=1 and flush_id_ex=1 in the same cycle and force stall_if_id=0.
REQ-023 Simultaneous branch-taken and load-use: branch SHALL win; no stall.
REQ-024 Stall and flush outputs SHALL be combinational; shadow update uses their values in the same cycle.

Reset
REQ-025 While rst_n=0 at a clock edge, all shadow entries SHALL become bubbles.
REQ-026 After reset: fwd_a_sel=fwd_b_sel=2'b00, stall_if_id=0, flush_if_id=0, flush_id_ex=0 (decode inputs ignored during reset cycle).
REQ-027 Reset mid-stall SHALL cancel the stall; no pending hazard survives reset.

Configuration
REQ-028 Macro HAZARD_PERF_CNT_EN defined: outputs stall_count and flush_count (CNT_W each) SHALL exist, increment once per cycle with stall_if_id / flush_if_id high, saturate at all-ones, clear on reset.
REQ-029 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package hazard_pkg SHALL hold select-code constants (FWD_RF, FWD_WB, FWD_MEM) and the shadow-entry typedef.
REQ-031 Sub-module fwd_select (one operand's priority comparison) SHALL be instantiated twice.

Verification
REQ-032 add x5 then add x6,x5,x1 back-to-back -> fwd_a_sel=2'b10 in second instruction's EX cycle.
REQ-033 add x5; nop; sub x7,x1,x5 -> fwd_b_sel=2'b01; add x5 twice then use -> 2'b10 (MEM priority).
REQ-034 lw x8 then add x9,x8,x2 -> one cycle stall_if_id=1, flush_id_ex=1, then fwd_a_sel=2'b01.
REQ-035 Writes to x0 followed by reads of x0 -> selects stay 2'b00, no stall.
REQ-036 ex_branch_taken=1 coincident with load-use -> flush_if_id=flush_id_ex=1, stall_if_id=0.
REQ-037 rst_n=0 during stall, release -> all outputs 0, counters (if enabled) 0; 2^CNT_W stall cycles -> stall_count holds all-ones.
